// File: rtl/gpio_led_periph.sv
// Memory-mapped GPIO / LED peripheral: set/clear/toggle on the GPIO port plus per-LED duty registers.
// Define LED_PWM_EN to build the 8-bit PWM engine; otherwise each LED simply follows bit 7 of its duty register.
//
// state | meaning
// IDLE  | waiting for bus_valid; the write and read capture happen on the accepting edge
// ACK   | bus_ready high for one cycle, bus_valid ignored
module gpio_led_periph #(
  parameter int          PWM_DIV  = 4,
  parameter logic [31:0] ID_VALUE = 32'h0000_6710
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  gpio_out,
  output logic        led_r_n,
  output logic        led_g_n,
  output logic        led_b_n
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t      state, state_nxt;
  logic [7:0]  out_q, duty_r, duty_g, duty_b;
  logic [7:0]  out_nxt, duty_r_nxt, duty_g_nxt, duty_b_nxt;
  logic [31:0] rdata_q, rdata_nxt;
  logic        unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // rdata_nxt defaults to 0 so the read bus clears itself once ACK ends.
  always_comb begin
    state_nxt  = state;
    out_nxt    = out_q;
    duty_r_nxt = duty_r;
    duty_g_nxt = duty_g;
    duty_b_nxt = duty_b;
    rdata_nxt  = '0;
    case (state)
      S_IDLE: begin
        if (bus_valid) begin
          state_nxt = S_ACK;
          if (bus_we) begin
            case (bus_addr)
              3'd0:    out_nxt = bus_wdata[7:0];
              3'd1:    out_nxt = out_q | bus_wdata[7:0];
              3'd2:    out_nxt = out_q & ~bus_wdata[7:0];
              3'd3:    out_nxt = out_q ^ bus_wdata[7:0];
              3'd4:    duty_r_nxt = bus_wdata[7:0];
              3'd5:    duty_g_nxt = bus_wdata[7:0];
              3'd6:    duty_b_nxt = bus_wdata[7:0];
              default: ;
            endcase
          end else begin
            case (bus_addr)
              3'd0, 3'd1, 3'd2, 3'd3: rdata_nxt = {24'd0, out_q};
              3'd4:    rdata_nxt = {24'd0, duty_r};
              3'd5:    rdata_nxt = {24'd0, duty_g};
              3'd6:    rdata_nxt = {24'd0, duty_b};
              default: rdata_nxt = ID_VALUE;
            endcase
          end
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      duty_r  <= '0;
      duty_g  <= '0;
      duty_b  <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_nxt;
      duty_r  <= duty_r_nxt;
      duty_g  <= duty_g_nxt;
      duty_b  <= duty_b_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  assign bus_ready = (state == S_ACK);
  assign bus_rdata = rdata_q;
  assign gpio_out  = out_q;

`ifdef LED_PWM_EN
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic [7:0]    pwm_cnt, act_r, act_g, act_b;

  assign presc_wrap = (presc == PW'(PWM_DIV - 1));

  // Shadow duties reload only at the 255->0 wrap so a period is never cut short.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      pwm_cnt <= '0;
      act_r   <= '0;
      act_g   <= '0;
      act_b   <= '0;
      led_r_n <= 1'b1;
      led_g_n <= 1'b1;
      led_b_n <= 1'b1;
    end else begin
      presc <= presc_wrap ? '0 : presc + PW'(1);
      if (presc_wrap) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'hFF) begin
          act_r <= duty_r;
          act_g <= duty_g;
          act_b <= duty_b;
        end
      end
      led_r_n <= ~(pwm_cnt < act_r);
      led_g_n <= ~(pwm_cnt < act_g);
      led_b_n <= ~(pwm_cnt < act_b);
    end
  end
`else
  // Registered from the next duty value so the LED changes in the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r_n <= 1'b1;
      led_g_n <= 1'b1;
      led_b_n <= 1'b1;
    end else begin
      led_r_n <= ~duty_r_nxt[7];
      led_g_n <= ~duty_g_nxt[7];
      led_b_n <= ~duty_b_nxt[7];
    end
  end
`endif

endmodule

// File: tb/tb_gpio_led_periph.sv
// Bench for gpio_led_periph: bus transactions scored through an expected-rdata queue,
// plus PWM low-time per period (LED_PWM_EN) or direct LED drive (default build).
module tb_gpio_led_periph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_we = 1'b0;
  logic [2:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  gpio_out;
  logic        led_r_n, led_g_n, led_b_n;

  gpio_led_periph #(.PWM_DIV(1), .ID_VALUE(32'h0000_6710)) dut (
    .clk(clk), .rst(rst),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .gpio_out(gpio_out), .led_r_n(led_r_n), .led_g_n(led_g_n), .led_b_n(led_b_n)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  out_m;
  logic [7:0]  ack_gpio;
  logic [2:0]  ack_led;
  int          cyc;
  int          acc_r, acc_g, acc_b;
  int          low_r, low_g, low_b;
  int          per_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // With PWM_DIV = 1 the PWM counter equals posedges since reset release, mod 256.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Output period k spans posedges 256k+1 .. 256k+256 (the LED register adds one cycle).
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= 0; acc_g <= 0; acc_b <= 0;
      per_cnt <= 0;
    end else if (cyc != 0 && cyc % 256 == 0) begin
      low_r <= acc_r + int'(!led_r_n);
      low_g <= acc_g + int'(!led_g_n);
      low_b <= acc_b + int'(!led_b_n);
      acc_r <= 0; acc_g <= 0; acc_b <= 0;
      per_cnt <= per_cnt + 1;
    end else begin
      acc_r <= acc_r + int'(!led_r_n);
      acc_g <= acc_g + int'(!led_g_n);
      acc_b <= acc_b + int'(!led_b_n);
    end
  end

  always @(negedge clk) begin
    if (bus_ready) begin
      if (exp_q.size() == 0) check_val("spurious_ready", 32'd1, 32'd0);
      else                   check_val("rdata", bus_rdata, exp_q.pop_front());
    end
  end

  task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp);
    int lat;
    bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus_ready && lat < 8);
    if (!bus_ready) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check_val("latency", lat, 32'd1);
    end
    ack_gpio = gpio_out;
    ack_led  = {led_r_n, led_g_n, led_b_n};
    bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    @(posedge clk); #1;
    check_val("ready_pulse", bus_ready, 32'd0);
    check_val("rdata_idle", bus_rdata, 32'd0);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
    bus_xfer(1'b1, addr, wdata, 32'd0);
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp);
    bus_xfer(1'b0, addr, 32'd0, exp);
  endtask

  task automatic wait_period();
    int start, n;
    start = per_cnt;
    n = 0;
    while (per_cnt == start && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (per_cnt == start) check_val("period_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] op_data [4];
    logic [2:0] op_addr [4];
    op_addr[0] = 3'd0; op_data[0] = 8'hA5;
    op_addr[1] = 3'd1; op_data[1] = 8'h0F;
    op_addr[2] = 3'd2; op_data[2] = 8'hA0;
    op_addr[3] = 3'd3; op_data[3] = 8'hFF;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", bus_ready, 32'd0);
    check_val("rst_rdata", bus_rdata, 32'd0);
    check_val("rst_gpio", gpio_out, 32'd0);
    check_val("rst_leds", {led_r_n, led_g_n, led_b_n}, 32'd7);
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rel_gpio", gpio_out, 32'd0);
    check_val("rel_leds", {led_r_n, led_g_n, led_b_n}, 32'd7);

    rd(3'd7, 32'h0000_6710);

    out_m = 8'h00;
    for (int i = 0; i < 4; i++) begin
      case (op_addr[i])
        3'd0:    out_m = op_data[i];
        3'd1:    out_m = out_m | op_data[i];
        3'd2:    out_m = out_m & ~op_data[i];
        default: out_m = out_m ^ op_data[i];
      endcase
      wr(op_addr[i], {24'h0, op_data[i]});
      check_val("gpio_in_ack", ack_gpio, out_m);
      check_val("gpio_out", gpio_out, out_m);
      rd(op_addr[i], {24'h0, out_m});
    end

    wr(3'd0, 32'hFFFF_FF3C);
    rd(3'd0, 32'h0000_003C);
    wr(3'd7, 32'h1234_5678);
    rd(3'd7, 32'h0000_6710);

    wr(3'd4, 32'h0000_0040);
    wr(3'd5, 32'h0000_0000);
    wr(3'd6, 32'h0000_00FF);
    rd(3'd4, 32'h0000_0040);
    rd(3'd5, 32'h0000_0000);
    rd(3'd6, 32'h0000_00FF);

`ifdef LED_PWM_EN
    wait_period();
    wait_period();
    check_val("low_r_40", low_r, 32'd64);
    check_val("low_g_00", low_g, 32'd0);
    check_val("low_b_ff", low_b, 32'd255);
    wr(3'd4, 32'h0000_00C0);
    wait_period();
    check_val("low_r_old", low_r, 32'd64);
    wait_period();
    check_val("low_r_new", low_r, 32'd192);
    check_val("low_b_ff2", low_b, 32'd255);
`else
    check_val("led_r_40", led_r_n, 32'd1);
    check_val("led_g_00", led_g_n, 32'd1);
    check_val("led_b_ff", led_b_n, 32'd0);
    wr(3'd5, 32'h0000_0080);
    check_val("led_g_80_ack", ack_led[1], 32'd0);
    check_val("led_g_80", led_g_n, 32'd0);
    wr(3'd5, 32'h0000_007F);
    check_val("led_g_7f_ack", ack_led[1], 32'd1);
    check_val("led_g_7f", led_g_n, 32'd1);
`endif

    // Reset lands in the ACK cycle of a write; no entry is queued for it.
    bus_valid = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = 32'h55;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    bus_valid = 1'b0; bus_we = 1'b0; bus_wdata = '0;
    check_val("abort_ready", bus_ready, 32'd0);
    check_val("abort_gpio", gpio_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("post_rst_gpio", gpio_out, 32'd0);
    check_val("post_rst_leds", {led_r_n, led_g_n, led_b_n}, 32'd7);
    rd(3'd0, 32'd0);
    rd(3'd4, 32'd0);
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
